apb_icn_resp: RTL
=================

# apb_icn_resp

Parametrised APB completer for the SPI-slave subsystem interconnect. It serves NCH select lines, each backed by a DEPTH-word register bank with byte-strobe writes. Wait states are programmable, and PSLVERR is raised on decode faults. It succeeds the fixed-data, random-ready bench stub with synthesizable, deterministic behaviour, and plugs into the same psel/penable/paddr bus used by the SPI-slave bench and top level.

## Interface
Parameters:
- NCH, 2: number of psel channels (1..8)
- ADDR_W, 20: paddr width
- DATA_W, 16: data width; multiple of 8
- DEPTH, 16: words per channel; power of 2
- WAIT_CYC, 1: fixed wait states inserted before PREADY (0..15)
- RESET_VAL, 16'hABCD: reset content of every register word

Ports (one clock `clk`; reset `reset_n` is asynchronous, active-low):
- clk  in  1  bus clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- psel  in  NCH  one-hot channel select
- penable  in  1  APB access phase
- paddr  in  ADDR_W  byte address
- pwrite  in  1  1 = write, 0 = read
- pwdata  in  DATA_W  write data
- pstrb  in  DATA_W/8  byte write strobes
- prdata_icn  out  DATA_W  read data, valid only with pready_icn
- pready_icn  out  1  transfer complete
- pslverr_icn  out  1  error, valid only with pready_icn

## Operation
- FSM states:
  - IDLE -> WAIT on a setup cycle (|psel & !penable) when WAIT_CYC > 0.
  - IDLE -> RESP on a setup cycle when WAIT_CYC == 0.
  - WAIT -> RESP when the wait counter reaches 0.
  - RESP -> IDLE unconditionally.
- Transfer latching:
  - Setup cycle latches channel index, word index `paddr[$clog2(DATA_W/8) +: $clog2(DEPTH)]`, pwrite, pwdata, pstrb and error flag.
  - Wait counter loads WAIT_CYC and decrements once per WAIT cycle.
- Error flag is set when any of these hold:
  - psel has more than one bit set
  - paddr is unaligned (low $clog2(DATA_W/8) bits nonzero)
  - paddr ≥ DEPTH*DATA_W/8
- RESP cycle outputs:
  - pready_icn = 1; pslverr_icn = error flag.
  - Read: prdata_icn = addressed word, or 0 on error.
  - Write: bytes with pstrb[i] = 1 update at the end of RESP; errored writes never update storage.
- prdata_icn is 0 whenever pready_icn is 0.
- Abort: psel falling to 0 during WAIT or RESP returns the FSM to IDLE without a write and without pready.
- Back-to-back transfers: a setup cycle arriving in the cycle after RESP is accepted normally.
- Reset, including mid-transfer:
  - FSM -> IDLE; all outputs 0; every register word = RESET_VAL.
  - No partial write survives.

## Timing
- Setup cycle is T0 and the first access cycle is T1; pready_icn rises at T1+WAIT_CYC for exactly one cycle.
- pready_icn, pslverr_icn and prdata_icn are all registered; there is no combinational path from any input to any output.
- A read issued at the T+1 after a write's RESP returns the new data.

## Configuration
- Macro `APB_ICN_RANDOM_WAIT_EN`.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5, reloaded on reset) advances once per accepted setup cycle.
  - Wait count for that transfer = WAIT_CYC + lfsr[1:0].
  - The LFSR sequence is deterministic, so benches can reproduce it.
- Undefined: no LFSR logic is present, and the wait count is exactly WAIT_CYC.

## Structure
- Package `apb_icn_pkg` holds:
  - state enum (IDLE, WAIT, RESP)
  - LFSR seed and tap constants
  - WAIT counter width (4 bits + 2 bits of headroom for the LFSR term)
- Sub-module `apb_icn_regbank`, one instance per channel, generated over NCH:
  - ports: DEPTH x DATA_W array, byte-strobe write port, async read port
  - reset to RESET_VAL
- The FSM, decode and output registers live in the top-level module.

## Test plan
All scenarios use default parameters unless stated.
- Reset, then read ch0 addr 0x00000 → pready at T1+1, prdata 16'hABCD, pslverr 0.
- Write ch1 addr 0x00006, data 16'h1234, pstrb 2'b01, then read it back → 16'hAB34; ch0 addr 0x00006 still reads 16'hABCD.
- Error cases, each returning pslverr 1 with prdata 0 and a later read confirming no write:
  - unaligned addr 0x00003
  - out-of-range addr 0x00020
  - psel 2'b11
- WAIT_CYC = 0 and WAIT_CYC = 3 builds: pready rises at T1 and at T1+3 respectively.
- Drop psel during WAIT of a write to addr 0x00002 → no pready; reading 0x00002 afterwards returns 16'hABCD.
- With `APB_ICN_RANDOM_WAIT_EN`: over 8 transfers, each wait count equals 1 + the low 2 bits of the LFSR sequence from seed 8'hA5. Assert reset mid-WAIT → outputs 0 and the LFSR returns to 8'hA5.

Source files
------------

// File: rtl/apb_icn_pkg.sv
// Shared types and constants for the APB interconnect completer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, LFSR seed/taps for the optional random-wait
// build (APB_ICN_RANDOM_WAIT_EN), and the wait-counter width.
package apb_icn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4 -> bit positions 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // 4 bits for WAIT_CYC (0..15) plus 2 bits for the lfsr[1:0] term.
    localparam int WCNT_W = 6;

endpackage

// File: rtl/apb_icn_resp_if.sv
// APB bus bundle between the requester and apb_icn_resp.
// Latency: n/a (wires only).
// Backpressure: completer stalls the requester via pready_icn.
// Ports: psel/penable/paddr/pwrite/pwdata/pstrb (requester -> completer),
//        prdata_icn/pready_icn/pslverr_icn (completer -> requester).
interface apb_icn_resp_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic [NCH-1:0]      psel;
    logic                penable;
    logic [ADDR_W-1:0]   paddr;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
    logic [DATA_W-1:0]   prdata_icn;
    logic                pready_icn;
    logic                pslverr_icn;

    modport master (
        output psel, penable, paddr, pwrite, pwdata, pstrb,
        input  prdata_icn, pready_icn, pslverr_icn
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata, pstrb,
        output prdata_icn, pready_icn, pslverr_icn
    );
endinterface

// File: rtl/apb_icn_regbank.sv
// One channel's DEPTH x DATA_W register bank, byte-strobe write, async read.
// Latency: write lands on the clock edge with we_i high; read is combinational.
// Backpressure: none; always accepts.
// Ports: clk, reset_n, we_i, waddr_i, wdata_i, wstrb_i, raddr_i, rdata_o.
module apb_icn_regbank #(
    parameter int                DATA_W    = 16,
    parameter int                DEPTH     = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = 16'hABCD,
    localparam int               IDX_W     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic [IDX_W-1:0]    raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
        end else if (we_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/apb_icn_resp.sv
// APB completer: NCH select lines, each backed by a DEPTH-word register bank.
// Latency: pready_icn at T1+WAIT_CYC (plus lfsr[1:0] with APB_ICN_RANDOM_WAIT_EN).
// Backpressure: holds pready_icn low for the wait states; psel drop aborts.
// Ports: clk, reset_n (async active-low), bus (apb_icn_resp_if.slave).
// Optional feature macro: APB_ICN_RANDOM_WAIT_EN (LFSR-extended wait states).
module apb_icn_resp
    import apb_icn_pkg::*;
#(
    parameter int                NCH       = 2,
    parameter int                ADDR_W    = 20,
    parameter int                DATA_W    = 16,
    parameter int                DEPTH     = 16,
    parameter int                WAIT_CYC  = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = 16'hABCD
) (
    input  logic           clk,
    input  logic           reset_n,
    apb_icn_resp_if.slave  bus
);
    localparam int BYTES = DATA_W/8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W+1)'(DEPTH * BYTES);

    state_t              state_q;
    logic [WCNT_W-1:0]   cnt_q;
    logic [CH_W-1:0]     ch_q;
    logic [IDX_W-1:0]    idx_q;
    logic                wr_q;
    logic                err_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BYTES-1:0]    strb_q;
    logic                pready_q;
    logic                pslverr_q;
    logic [DATA_W-1:0]   prdata_q;

    logic                sel_any;
    logic                setup;
    logic [CH_W-1:0]     ch_d;
    logic [IDX_W-1:0]    idx_d;
    logic                err_d;
    logic [WCNT_W-1:0]   wait_d;
    logic [CH_W-1:0]     rd_ch;
    logic [IDX_W-1:0]    rd_idx;
    logic [DATA_W-1:0]   rd_word [NCH];
    logic [DATA_W-1:0]   rd_sel;
    logic                wr_go;

`ifdef APB_ICN_RANDOM_WAIT_EN
    logic [7:0] lfsr_q;
`endif

    // Setup-cycle decode: channel, word index, fault and wait count.
    always_comb begin
        sel_any = |bus.psel;
        setup   = sel_any & ~bus.penable;
        ch_d    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.psel[i]) ch_d = CH_W'(i);
        end
        idx_d  = bus.paddr[OFF_W +: IDX_W];
        err_d  = ((bus.psel & (bus.psel - NCH'(1))) != '0)   // multi-hot select
               || ((bus.paddr & OFF_MASK) != '0)             // unaligned
               || ({1'b0, bus.paddr} >= LIMIT);              // beyond the bank
`ifdef APB_ICN_RANDOM_WAIT_EN
        wait_d = WCNT_W'(WAIT_CYC) + WCNT_W'(lfsr_q[1:0]);
`else
        wait_d = WCNT_W'(WAIT_CYC);
`endif
    end

    // With zero wait states RESP is entered straight from the setup cycle,
    // so the read must use the live decode rather than the latched one.
    always_comb begin
        rd_ch  = (state_q == IDLE) ? ch_d  : ch_q;
        rd_idx = (state_q == IDLE) ? idx_d : idx_q;
        rd_sel = rd_word[rd_ch];
    end

    // Commit on the edge closing RESP, only if the requester is still there.
    assign wr_go = (state_q == RESP) && sel_any && wr_q && !err_q;

    for (genvar g = 0; g < NCH; g++) begin : g_bank
        apb_icn_regbank #(
            .DATA_W    (DATA_W),
            .DEPTH     (DEPTH),
            .RESET_VAL (RESET_VAL)
        ) u_bank (
            .clk     (clk),
            .reset_n (reset_n),
            .we_i    (wr_go && (ch_q == CH_W'(g))),
            .waddr_i (idx_q),
            .wdata_i (wdata_q),
            .wstrb_i (strb_q),
            .raddr_i (rd_idx),
            .rdata_o (rd_word[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
`ifdef APB_ICN_RANDOM_WAIT_EN
            lfsr_q    <= LFSR_SEED;
`endif
        end else begin
            // Outputs are single-cycle pulses; only the RESP entry raises them.
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (setup) begin
                        ch_q    <= ch_d;
                        idx_q   <= idx_d;
                        wr_q    <= bus.pwrite;
                        err_q   <= err_d;
                        wdata_q <= bus.pwdata;
                        strb_q  <= bus.pstrb;
`ifdef APB_ICN_RANDOM_WAIT_EN
                        lfsr_q  <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
`endif
                        if (wait_d == '0) begin
                            state_q   <= RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= err_d;
                            prdata_q  <= (err_d || bus.pwrite) ? '0 : rd_sel;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= wait_d;
                        end
                    end
                end
                WAIT: begin
                    if (!sel_any) begin
                        state_q <= IDLE;
                    end else if (cnt_q == WCNT_W'(1)) begin
                        state_q   <= RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= err_q;
                        prdata_q  <= (err_q || wr_q) ? '0 : rd_sel;
                    end else begin
                        cnt_q <= cnt_q - WCNT_W'(1);
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pready_icn  = pready_q;
    assign bus.pslverr_icn = pslverr_q;
    assign bus.prdata_icn  = prdata_q;
endmodule
